// File: rtl/device_bus_pkg.sv
// Shared types and default address map for the device bus router and its decoder.
package device_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } router_state_t;

    typedef enum logic [1:0] {
        TGT_UART,
        TGT_TIMER,
        TGT_NONE
    } target_t;

    localparam logic [31:0] DEF_UART_BASE  = 32'hC000_0000;
    localparam logic [31:0] DEF_UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] DEF_TIMER_BASE = 32'hF000_0000;
    localparam logic [31:0] DEF_TIMER_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_ERR_DATA   = 32'hDEAD_BEEF;

    localparam int TMO_CNT_WIDTH = 16;

endpackage

// File: rtl/device_addr_decoder.sv
// Combinational address-to-target decode; UART window takes precedence over timer.
module device_addr_decoder
    import device_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] UART_BASE  = DEF_UART_BASE,
    parameter logic [ADDR_WIDTH-1:0] UART_MASK  = DEF_UART_MASK,
    parameter logic [ADDR_WIDTH-1:0] TIMER_BASE = DEF_TIMER_BASE,
    parameter logic [ADDR_WIDTH-1:0] TIMER_MASK = DEF_TIMER_MASK
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output target_t               target_o
);

    always_comb begin
        if ((addr_i & UART_MASK) == UART_BASE) begin
            target_o = TGT_UART;
        end else if ((addr_i & TIMER_MASK) == TIMER_BASE) begin
            target_o = TGT_TIMER;
        end else begin
            target_o = TGT_NONE;
        end
    end

endmodule

// File: rtl/device_bus_router.sv
// Routes single-outstanding core requests to the UART or timer model, holding the
// request at the device until it answers; misses and timeouts return ERR_DATA.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for S_strobe; request and target latched on accept
// ST_ISSUE | strobe the target once its previous data_ready has dropped
// ST_WAIT  | request held at the target; timeout counter running
// ST_RESP  | one-cycle S_data_ready with S_dev2core_data valid
module device_bus_router
    import device_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] UART_BASE  = DEF_UART_BASE,
    parameter logic [ADDR_WIDTH-1:0] UART_MASK  = DEF_UART_MASK,
    parameter logic [ADDR_WIDTH-1:0] TIMER_BASE = DEF_TIMER_BASE,
    parameter logic [ADDR_WIDTH-1:0] TIMER_MASK = DEF_TIMER_MASK,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      S_strobe,
    input  logic [ADDR_WIDTH-1:0]     S_addr,
    input  logic                      S_rw,
    input  logic [DATA_WIDTH/8-1:0]   S_byte_enable,
    input  logic [DATA_WIDTH-1:0]     S_core2dev_data,
    output logic                      S_data_ready,
    output logic [DATA_WIDTH-1:0]     S_dev2core_data,
    output logic                      S_busy,
    output logic                      bus_error,
    input  logic                      err_clear,

    output logic                      U_strobe,
    output logic [ADDR_WIDTH-1:0]     U_addr,
    output logic                      U_rw,
    output logic [DATA_WIDTH/8-1:0]   U_byte_enable,
    output logic [DATA_WIDTH-1:0]     U_core2dev_data,
    input  logic                      U_data_ready,
    input  logic [DATA_WIDTH-1:0]     U_dev2core_data,

    output logic                      T_strobe,
    output logic [ADDR_WIDTH-1:0]     T_addr,
    output logic                      T_rw,
    output logic [DATA_WIDTH/8-1:0]   T_byte_enable,
    output logic [DATA_WIDTH-1:0]     T_core2dev_data,
    input  logic                      T_data_ready,
    input  logic [DATA_WIDTH-1:0]     T_dev2core_data
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [TMO_CNT_WIDTH-1:0] CNT_LAST = TMO_CNT_WIDTH'(TIMEOUT - 1);

    router_state_t state_q, state_d;
    target_t       tgt_q, hit_tgt;

    logic [TMO_CNT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;

    logic [ADDR_WIDTH-1:0]    u_addr_q, t_addr_q;
    logic                     u_rw_q, t_rw_q;
    logic [BE_WIDTH-1:0]      u_be_q, t_be_q;
    logic [DATA_WIDTH-1:0]    u_wdata_q, t_wdata_q;

    logic                     sel_ready;
    logic [DATA_WIDTH-1:0]    sel_rdata;
    logic                     accept, timeout, err_set;

    device_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .UART_BASE  (UART_BASE),
        .UART_MASK  (UART_MASK),
        .TIMER_BASE (TIMER_BASE),
        .TIMER_MASK (TIMER_MASK)
    ) u_decoder (
        .addr_i   (S_addr),
        .target_o (hit_tgt)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (tgt_q)
            TGT_UART: begin
                sel_ready = U_data_ready;
                sel_rdata = U_dev2core_data;
            end
            TGT_TIMER: begin
                sel_ready = T_data_ready;
                sel_rdata = T_dev2core_data;
            end
            default: ;
        endcase
    end

    assign accept  = (state_q == ST_IDLE) && S_strobe;
    assign timeout = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    // A ready arriving in the final WAIT cycle wins over the timeout.
    assign err_set = (accept && (hit_tgt == TGT_NONE)) || (timeout && !sel_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (S_strobe) begin
                    state_d = (hit_tgt == TGT_NONE) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!sel_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sel_ready || timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S_busy       = (state_q != ST_IDLE);
        S_data_ready = (state_q == ST_RESP);
        U_strobe     = (state_q == ST_ISSUE) && (tgt_q == TGT_UART) && !U_data_ready;
        T_strobe     = (state_q == ST_ISSUE) && (tgt_q == TGT_TIMER) && !T_data_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_q     <= TGT_NONE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            u_addr_q  <= '0;
            u_rw_q    <= 1'b0;
            u_be_q    <= '0;
            u_wdata_q <= '0;
            t_addr_q  <= '0;
            t_rw_q    <= 1'b0;
            t_be_q    <= '0;
            t_wdata_q <= '0;
        end else begin
            cnt_q <= (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;

            if (accept) begin
                tgt_q <= hit_tgt;
                if (hit_tgt == TGT_UART) begin
                    u_addr_q  <= S_addr;
                    u_rw_q    <= S_rw;
                    u_be_q    <= S_byte_enable;
                    u_wdata_q <= S_core2dev_data;
                end
                if (hit_tgt == TGT_TIMER) begin
                    t_addr_q  <= S_addr;
                    t_rw_q    <= S_rw;
                    t_be_q    <= S_byte_enable;
                    t_wdata_q <= S_core2dev_data;
                end
                if (hit_tgt == TGT_NONE) begin
                    rdata_q <= ERR_DATA;
                end
            end

            if (state_q == ST_WAIT) begin
                if (sel_ready) begin
                    rdata_q <= sel_rdata;
                end else if (timeout) begin
                    rdata_q <= ERR_DATA;
                end
            end

            if (err_clear) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign S_dev2core_data = rdata_q;
    assign bus_error       = err_q;

    assign U_addr          = u_addr_q;
    assign U_rw            = u_rw_q;
    assign U_byte_enable   = u_be_q;
    assign U_core2dev_data = u_wdata_q;

    assign T_addr          = t_addr_q;
    assign T_rw            = t_rw_q;
    assign T_byte_enable   = t_be_q;
    assign T_core2dev_data = t_wdata_q;

endmodule

// File: tb/tb_device_bus_router.sv
// Randomised bench for device_bus_router with latency-programmable UART/timer models
// and a transaction-level reference for completion cycle, data and error flag.
module tb_device_bus_router;

    localparam int          TMO   = 12;
    localparam logic [31:0] UBASE = 32'hC000_0000;
    localparam logic [31:0] UMASK = 32'hFFFF_F000;
    localparam logic [31:0] TBASE = 32'hF000_0000;
    localparam logic [31:0] TMASK = 32'hFFFF_0000;
    localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;
    localparam logic [31:0] USTAT = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        S_strobe = 1'b0, S_rw = 1'b0, err_clear = 1'b0;
    logic [31:0] S_addr = '0, S_core2dev_data = '0;
    logic [3:0]  S_byte_enable = '0;
    logic        S_data_ready, S_busy, bus_error;
    logic [31:0] S_dev2core_data;
    logic        U_strobe, U_rw, T_strobe, T_rw;
    logic [31:0] U_addr, U_core2dev_data, T_addr, T_core2dev_data;
    logic [3:0]  U_byte_enable, T_byte_enable;
    logic        U_data_ready = 1'b0, T_data_ready = 1'b0;
    logic [31:0] U_dev2core_data = '0, T_dev2core_data = '0;

    device_bus_router #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_strobe(S_strobe), .S_addr(S_addr), .S_rw(S_rw), .S_byte_enable(S_byte_enable),
        .S_core2dev_data(S_core2dev_data), .S_data_ready(S_data_ready),
        .S_dev2core_data(S_dev2core_data), .S_busy(S_busy), .bus_error(bus_error),
        .err_clear(err_clear),
        .U_strobe(U_strobe), .U_addr(U_addr), .U_rw(U_rw), .U_byte_enable(U_byte_enable),
        .U_core2dev_data(U_core2dev_data), .U_data_ready(U_data_ready),
        .U_dev2core_data(U_dev2core_data),
        .T_strobe(T_strobe), .T_addr(T_addr), .T_rw(T_rw), .T_byte_enable(T_byte_enable),
        .T_core2dev_data(T_core2dev_data), .T_data_ready(T_data_ready),
        .T_dev2core_data(T_dev2core_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if ((a & UMASK) == UBASE) return 0;
        if ((a & TMASK) == TBASE) return 1;
        return 2;
    endfunction

    // Data each device model returns; on writes the router must pass it through untouched.
    function automatic logic [31:0] dev_fn(input int tgt, input logic [31:0] a,
                                           input logic rw, input logic [31:0] wd);
        if (tgt == 0) return rw ? ~wd : ((a[11:0] == 12'h008) ? USTAT : {a[15:0], 16'hA5A5});
        return rw ? (wd ^ 32'h1234_5678) : (a ^ 32'h0F0F_0F0F);
    endfunction

    // Device models: ready arrives lat cycles after the strobe (lat 0 = never) and stays
    // high hold_len cycles. Driven at +2, strobe sampled at +3, stimulus lives at +1.
    int          u_lat = 1, u_hold_len = 1, u_rem = 0, u_hold = 0, u_strobes = 0, u_tx_cnt = 0;
    int          t_lat = 1, t_hold_len = 1, t_rem = 0, t_hold = 0, t_strobes = 0;
    logic [7:0]  u_tx_char = '0;
    logic [68:0] u_saw = '0, t_saw = '0;
    logic        u_busy = 1'b0, u_unstable = 1'b0, t_busy = 1'b0, t_unstable = 1'b0;

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            u_rem = 0; u_hold = 0; u_busy = 1'b0; U_data_ready = 1'b0;
        end else begin
            if (u_rem > 0) begin
                u_rem--;
                if (u_rem == 0) u_hold = u_hold_len;
            end
            U_data_ready = (u_hold > 0);
            if (u_hold > 0) u_hold--;
            if (U_data_ready) U_dev2core_data = dev_fn(0, u_saw[68:37], u_saw[36], u_saw[31:0]);
            if (u_busy && ({U_addr, U_rw, U_byte_enable, U_core2dev_data} != u_saw)) u_unstable = 1'b1;
            if (U_data_ready || S_data_ready) u_busy = 1'b0;
        end
        #1;
        if (rst_n && U_strobe) begin
            u_strobes++;
            u_saw  = {U_addr, U_rw, U_byte_enable, U_core2dev_data};
            u_rem  = u_lat;
            u_busy = 1'b1;
            if (U_rw && U_addr[11:0] == 12'h004) begin
                u_tx_cnt++;
                u_tx_char = U_core2dev_data[7:0];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            t_rem = 0; t_hold = 0; t_busy = 1'b0; T_data_ready = 1'b0;
        end else begin
            if (t_rem > 0) begin
                t_rem--;
                if (t_rem == 0) t_hold = t_hold_len;
            end
            T_data_ready = (t_hold > 0);
            if (t_hold > 0) t_hold--;
            if (T_data_ready) T_dev2core_data = dev_fn(1, t_saw[68:37], t_saw[36], t_saw[31:0]);
            if (t_busy && ({T_addr, T_rw, T_byte_enable, T_core2dev_data} != t_saw)) t_unstable = 1'b1;
            if (T_data_ready || S_data_ready) t_busy = 1'b0;
        end
        #1;
        if (rst_n && T_strobe) begin
            t_strobes++;
            t_saw  = {T_addr, T_rw, T_byte_enable, T_core2dev_data};
            t_rem  = t_lat;
            t_busy = 1'b1;
        end
    end

    // Transaction-level reference state.
    logic        exp_err = 1'b0;
    logic [68:0] last_u = '0, last_t = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_dready"}, S_data_ready, 1'b0);
        check_eq({tag, "_busy"}, S_busy, 1'b0);
        check_eq({tag, "_err"}, bus_error, 1'b0);
        check_eq({tag, "_rdata"}, S_dev2core_data, 32'h0);
        check_eq({tag, "_ustb"}, U_strobe, 1'b0);
        check_eq({tag, "_ureq"}, {U_addr, U_rw, U_byte_enable, U_core2dev_data}, 69'h0);
        check_eq({tag, "_treq"}, {T_addr, T_rw, T_byte_enable, T_core2dev_data}, 69'h0);
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check_eq("err_clear", bus_error, 1'b0);
        exp_err = 1'b0;
    endtask

    // Issues one request in the current (idle) cycle; returns in the cycle after S_data_ready.
    task automatic run_txn(input logic [31:0] a, input logic rw, input logic [3:0] be,
                           input logic [31:0] wd, input logic clr, input logic extra);
        int          tgt, s, r, st, exp_r, lat, ready_end, us0, ts0;
        logic [31:0] exp_d;
        logic        sets, exp_e;
        logic [68:0] req, exp_u, exp_t;
        tgt = decode(a);
        req = {a, rw, be, wd};
        s   = cyc;
        us0 = u_strobes;
        ts0 = t_strobes;
        u_unstable = 1'b0;
        t_unstable = 1'b0;
        if (tgt == 2) begin
            exp_r = s + 1; exp_d = ERRW; sets = 1'b1;
        end else begin
            lat       = (tgt == 0) ? u_lat : t_lat;
            ready_end = (tgt == 0) ? ((u_hold > 0) ? s - 1 + u_hold : -1)
                                   : ((t_hold > 0) ? s - 1 + t_hold : -1);
            st = (ready_end + 1 > s + 1) ? ready_end + 1 : s + 1;
            if (lat == 0) begin
                exp_r = st + TMO + 1; exp_d = ERRW; sets = 1'b1;
            end else begin
                exp_r = st + lat + 1; exp_d = dev_fn(tgt, a, rw, wd); sets = 1'b0;
            end
        end
        exp_e = (sets && !(clr && tgt == 2)) || (exp_err && !clr);
        exp_u = (tgt == 0) ? req : last_u;
        exp_t = (tgt == 1) ? req : last_t;

        S_addr = a; S_rw = rw; S_byte_enable = be; S_core2dev_data = wd;
        S_strobe = 1'b1; err_clear = clr;
        r = -1;
        for (int i = 0; i < 2 * TMO + 40; i++) begin
            step();
            err_clear = 1'b0;
            if (extra) begin
                S_strobe = 1'b1; S_addr = 32'h8000_0000; S_rw = ~rw; S_core2dev_data = ~wd;
            end else begin
                S_strobe = 1'b0;
            end
            if (i == 0) check_eq("busy", S_busy, 1'b1);
            if (S_data_ready) begin
                r = cyc;
                break;
            end
        end
        check_eq("resp_seen", r >= 0, 1'b1);
        check_eq("resp_latency", r - s, exp_r - s);
        check_eq("rdata", S_dev2core_data, exp_d);
        check_eq("bus_error", bus_error, exp_e);
        check_eq("u_strobes", u_strobes - us0, (tgt == 0) ? 1 : 0);
        check_eq("t_strobes", t_strobes - ts0, (tgt == 1) ? 1 : 0);
        check_eq("u_req", {U_addr, U_rw, U_byte_enable, U_core2dev_data}, exp_u);
        check_eq("t_req", {T_addr, T_rw, T_byte_enable, T_core2dev_data}, exp_t);
        if (tgt == 0) check_eq("u_saw", u_saw, req);
        if (tgt == 1) check_eq("t_saw", t_saw, req);
        check_eq("u_stable", u_unstable, 1'b0);
        check_eq("t_stable", t_unstable, 1'b0);
        step();
        S_strobe = 1'b0;
        check_eq("dready_pulse", S_data_ready, 1'b0);
        check_eq("rdata_hold", S_dev2core_data, exp_d);
        check_eq("idle_busy", S_busy, 1'b0);
        exp_err = exp_e;
        last_u  = exp_u;
        last_t  = exp_t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0, sel, lat, seen;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        step();

        u_lat = 10; u_hold_len = 1; tx0 = u_tx_cnt;
        run_txn(32'hC000_0004, 1'b1, 4'h1, 32'h0000_0041, 1'b0, 1'b0);
        check_eq("tx_count", u_tx_cnt - tx0, 1);
        check_eq("tx_char", u_tx_char, 8'h41);

        u_lat = 3;
        run_txn(32'hC000_0008, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        run_txn(32'h8000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        clear_err();

        t_lat = 0;
        run_txn(32'hF000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        clear_err();

        u_lat = TMO;
        run_txn(32'hC000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        u_lat = 5;
        run_txn(32'hC000_000C, 1'b1, 4'h3, 32'hCAFE_0123, 1'b0, 1'b1);

        u_lat = 2; u_hold_len = 6;
        run_txn(32'hC000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        u_lat = 4; u_hold_len = 1;
        run_txn(32'hC000_0014, 1'b1, 4'hF, 32'h1111_2222, 1'b0, 1'b0);

        run_txn(32'h1234_5678, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        run_txn(32'h8000_0100, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);

        t_lat = 7; t_hold_len = 1;
        run_txn(32'hF000_ABC0, 1'b1, 4'hC, 32'h5555_AAAA, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = UBASE | 32'($urandom_range(0, 4095));
            else if (sel < 8) a = TBASE | 32'($urandom_range(0, 65535));
            else              a = $urandom;
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
            u_lat = lat; t_lat = lat;
            u_hold_len = $urandom_range(1, 5);
            t_hold_len = $urandom_range(1, 5);
            run_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end

        repeat (6) step();
        u_lat = 10; u_hold_len = 1;
        S_addr = 32'hC000_0008; S_rw = 1'b0; S_byte_enable = 4'hF; S_strobe = 1'b1;
        step();
        S_strobe = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state("midrst");
        exp_err = 1'b0; last_u = '0; last_t = '0;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (S_data_ready) seen++;
            step();
        end
        check_eq("midrst_no_dready", seen, 0);

        tx0 = u_tx_cnt;
        run_txn(32'hC000_0004, 1'b1, 4'h1, 32'h0000_0042, 1'b0, 1'b0);
        check_eq("post_rst_tx", u_tx_cnt - tx0, 1);
        check_eq("post_rst_char", u_tx_char, 8'h42);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/device_bus_router.md
# device_bus_router

Routes single-outstanding device requests from the Aquila core's device port to one of two memory-mapped device models: the UART model and the timer model. It sits directly upstream of the UART model in the verilated platform. It decodes the address and holds the request stable at the selected device until that device returns `data_ready`. Misses and device timeouts complete with an error word so the core never hangs.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `UART_BASE`, 32'hC000_0000, UART window base.
- `UART_MASK`, 32'hFFFF_F000, UART window mask.
- `TIMER_BASE`, 32'hF000_0000, timer window base.
- `TIMER_MASK`, 32'hFFFF_0000, timer window mask.
- `TIMEOUT`, 255, WAIT cycles before abort (1..65535).
- `ERR_DATA`, 32'hDEADBEEF, read data returned on miss or timeout.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `S_strobe` in 1: core request pulse.
- `S_addr` in ADDR_WIDTH: core request address.
- `S_rw` in 1: 1 = write.
- `S_byte_enable` in DATA_WIDTH/8: core byte enables.
- `S_core2dev_data` in DATA_WIDTH: core write data.
- `S_data_ready` out 1: one-cycle completion pulse.
- `S_dev2core_data` out DATA_WIDTH: read data.
- `S_busy` out 1: high in every state except IDLE.
- `bus_error` out 1: sticky error flag.
- `err_clear` in 1: clears `bus_error`.
- `U_strobe`, `U_addr`, `U_rw`, `U_byte_enable`, `U_core2dev_data`: UART-side request (out), same widths as the S_ equivalents.
- `U_data_ready`, `U_dev2core_data`: UART-side response (in).
- `T_*`: identical set for the timer.

## Operation
- A device is hit when (addr & MASK) == BASE. UART is checked first; if neither matches, the request is a miss.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when `S_strobe`=1, latch addr/rw/be/wdata and the decoded target.
  - Hit → ISSUE.
  - Miss → RESP with data=ERR_DATA and `bus_error` set.
- ISSUE: if the target's `data_ready` is still high from a previous transaction, stay in ISSUE. Otherwise drive the target's strobe for exactly this cycle → WAIT.
- WAIT: the target's addr/rw/be/wdata are held at the latched values; the timeout counter increments each cycle.
  - Target `data_ready`=1 → capture its `dev2core_data` → RESP.
  - Counter reaches TIMEOUT → data=ERR_DATA, `bus_error` set → RESP.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP: `S_data_ready`=1 for this single cycle; `S_dev2core_data` valid → IDLE.

Rules:
- `S_strobe` is ignored outside IDLE, including a strobe in the RESP cycle. The core must wait for `S_data_ready`.
- The non-selected device sees strobe=0 with addr/data held at their last value (0 after reset).
- A device `data_ready` is ignored except in WAIT for the selected device.
- `bus_error`: `err_clear` has priority over a same-cycle set.
- `S_dev2core_data` holds its value until the next RESP. On a write, the device's returned data is passed through unchanged.

## Timing
- Reset values: every output is 0, `S_dev2core_data`=0, state IDLE, counter 0.
- Reset mid-transaction aborts to IDLE the next cycle with no `S_data_ready`. The device model is reset by the same `rst_n`.
- Miss: strobe sampled at edge n → `S_data_ready` high in cycle n+1.
- Hit:
  - Device strobe is high in cycle n+1.
  - Device `data_ready` seen in WAIT cycle m → `S_data_ready` in cycle m+1.
  - Added latency is 2 cycles over the device.
- Timeout: `S_data_ready` arrives TIMEOUT+2 cycles after `S_strobe`.
- All outputs are registered or decoded directly from the state register; there is no combinational path from S_ inputs to S_ outputs.

## Structure
- Package `device_bus_pkg`:
  - state enum `router_state_t`;
  - target enum {TGT_UART, TGT_TIMER, TGT_NONE};
  - default BASE/MASK constants and ERR_DATA.
- Sub-module `device_addr_decoder`: combinational address → target decode, reused by the future timer model bench.
- Timeout counter width is 16 bits.

## Test plan
- Write 0x41 to 0xC0000004 with the UART model attached (latency 10) → `U_strobe` pulses once; `U_addr` is stable until `U_data_ready`; `S_data_ready` is one cycle later; "A" is printed once.
- Read 0xC0000008 → `S_dev2core_data` = the UART status word; `bus_error`=0.
- Read 0x80000000 (miss) → `S_data_ready` at n+1, data 32'hDEADBEEF, `bus_error`=1. Then `err_clear` → 0.
- Timer stub never asserts ready, TIMEOUT=4 → `S_data_ready` 6 cycles after the strobe, data DEADBEEF, `bus_error`=1.
- Second strobe asserted during WAIT and in the RESP cycle → ignored; exactly one device strobe and one `S_data_ready`.
- `rst_n` low in the WAIT cycle → next cycle: IDLE, all outputs 0, no `S_data_ready`. A fresh UART write afterwards completes normally.
